// File: rtl/fpu_issue_sched_pkg.sv
// Shared constants for the FP issue scheduler: op-vector bit positions,
// the mask of ops whose result goes to a GPR, and the FSM encoding.
package fpu_issue_sched_pkg;

    localparam int OPW_DEF   = 24;
    localparam int CNT_W     = 4;

    localparam int OP_FDIV   = 3;
    localparam int OP_FSQRT  = 4;
    localparam int OP_FMVF   = 8;
    localparam int OP_FEQ    = 9;
    localparam int OP_FLT    = 10;
    localparam int OP_FLE    = 11;
    localparam int OP_FCVT_W = 14;
    localparam int OP_FCLASS = 21;

    // Ops whose architectural result lands in the integer register file.
    localparam logic [OPW_DEF-1:0] GPR_MASK = OPW_DEF'(
        (1 << OP_FMVF) | (1 << OP_FEQ) | (1 << OP_FLT) |
        (1 << OP_FLE)  | (1 << OP_FCVT_W) | (1 << OP_FCLASS));

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MDIV = 1'b1
    } sched_state_e;

    function automatic logic op_is_multicycle(input logic [OPW_DEF-1:0] op);
        return op[OP_FDIV] | op[OP_FSQRT];
    endfunction

endpackage

// File: rtl/fpu_issue_sched_if.sv
// Decode-side handshake plus execute/writeback strobes of the FP issue scheduler.
// master = decode/testbench side, slave = scheduler side.
interface fpu_issue_sched_if #(
    parameter int OPW = 24
);
    logic           dec_valid;
    logic           dec_ready;
    logic [OPW-1:0] dec_sfpu_op;
    logic [2:0]     dec_fs_en;
    logic [4:0]     dec_fs1_addr;
    logic [4:0]     dec_fs2_addr;
    logic [4:0]     dec_fs3_addr;
    logic [4:0]     dec_rd;

    logic           exu_valid;
    logic [OPW-1:0] exu_sfpu_op;
    logic           wb_valid;
    logic [4:0]     wb_rd;
    logic           wb_to_gpr;

    modport master (
        output dec_valid, dec_sfpu_op, dec_fs_en,
        output dec_fs1_addr, dec_fs2_addr, dec_fs3_addr, dec_rd,
        input  dec_ready, exu_valid, exu_sfpu_op, wb_valid, wb_rd, wb_to_gpr
    );

    modport slave (
        input  dec_valid, dec_sfpu_op, dec_fs_en,
        input  dec_fs1_addr, dec_fs2_addr, dec_fs3_addr, dec_rd,
        output dec_ready, exu_valid, exu_sfpu_op, wb_valid, wb_rd, wb_to_gpr
    );
endinterface

// File: rtl/fpu_issue_sched_scoreboard.sv
// FPR pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback (set wins on the same index), wiped by flush/reset.
module fpu_scoreboard #(
    parameter int NFPR = 32,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst_l,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic          i_flush,
    input  logic [AW-1:0] i_src1_idx,
    input  logic [AW-1:0] i_src2_idx,
    input  logic [AW-1:0] i_src3_idx,
    input  logic [AW-1:0] i_rd_idx,
    output logic [2:0]    o_src_hit,
    output logic          o_rd_hit
);

    logic [NFPR-1:0] r_pending;
    logic [NFPR-1:0] w_pending_next;

    genvar gi;
    generate
        for (gi = 0; gi < NFPR; gi++) begin : g_bit
            logic w_set;
            logic w_clr;
            assign w_set = i_set_en && (i_set_idx == AW'(gi));
            assign w_clr = i_clr_en && (i_clr_idx == AW'(gi));
            assign w_pending_next[gi] = w_set | (r_pending[gi] & ~w_clr);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_l || i_flush) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // Lookups use the registered bits only, so a same-cycle writeback does not bypass.
    assign o_src_hit[0] = r_pending[i_src1_idx];
    assign o_src_hit[1] = r_pending[i_src2_idx];
    assign o_src_hit[2] = r_pending[i_src3_idx];
    assign o_rd_hit     = r_pending[i_rd_idx];

endmodule

// File: rtl/fpu_issue_sched.sv
// FP issue scheduler: hazard-checked accept, 2-stage single-cycle pipeline and
// a serialising fdiv/fsqrt FSM. Optional perf counters under FPU_SCHED_PERF_EN.
module fpu_issue_sched
    import fpu_issue_sched_pkg::*;
#(
    parameter int NFPR    = 32,
    parameter int DIV_LAT = 8,
    parameter int OPW     = 24
) (
    input  logic                  clk,
    input  logic                  rst_l,
    input  logic                  flush,
    fpu_issue_sched_if.slave      bus,
    output logic                  busy
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_stall_cnt,
    output logic [31:0]           perf_issue_cnt
`endif
);

    localparam int AW = $clog2(NFPR);
    localparam logic [OPW-1:0] W_GPR_MASK = OPW'(GPR_MASK);

    logic [OPW-1:0] w_op;
    logic           w_op_valid;
    logic           w_is_div;
    logic           w_wr_gpr;
    logic           w_wr_fpr;
    logic [2:0]     w_src_hit_raw;
    logic           w_src_hit;
    logic           w_rd_hit;
    logic           w_stall;
    logic           w_ready;
    logic           w_accept;
    logic           w_wb_valid;

    sched_state_e   r_state;
    sched_state_e   w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic           w_div_done;
    logic [4:0]     r_div_rd;

    logic           r_exu_valid;
    logic [OPW-1:0] r_exu_op;
    logic           r_s1_valid;
    logic           r_s1_wb;
    logic           r_s1_gpr;
    logic [4:0]     r_s1_rd;
    logic           r_s2_valid;
    logic           r_s2_wb;
    logic           r_s2_gpr;
    logic [4:0]     r_s2_rd;

    // Op decode: anything not strictly one-hot is issued but never writes back.
    assign w_op       = bus.dec_sfpu_op;
    assign w_op_valid = $onehot(w_op);
    assign w_is_div   = w_op_valid & op_is_multicycle(OPW_DEF'(w_op));
    assign w_wr_gpr   = w_op_valid & (|(w_op & W_GPR_MASK));
    assign w_wr_fpr   = w_op_valid & ~w_wr_gpr;

    fpu_scoreboard #(
        .NFPR (NFPR),
        .AW   (AW)
    ) u_sb (
        .clk        (clk),
        .rst_l      (rst_l),
        .i_set_en   (w_accept & w_wr_fpr),
        .i_set_idx  (AW'(bus.dec_rd)),
        .i_clr_en   (w_wb_valid & ~r_s2_gpr),
        .i_clr_idx  (AW'(r_s2_rd)),
        .i_flush    (flush),
        .i_src1_idx (AW'(bus.dec_fs1_addr)),
        .i_src2_idx (AW'(bus.dec_fs2_addr)),
        .i_src3_idx (AW'(bus.dec_fs3_addr)),
        .i_rd_idx   (AW'(bus.dec_rd)),
        .o_src_hit  (w_src_hit_raw),
        .o_rd_hit   (w_rd_hit)
    );

    assign w_src_hit = |(w_src_hit_raw & bus.dec_fs_en);
    assign w_stall   = w_src_hit
                     | (w_wr_fpr & w_rd_hit)
                     | (r_state == ST_MDIV)
                     | flush
                     | (w_is_div & (r_s1_valid | r_s2_valid));
    assign w_ready   = rst_l & ~w_stall;
    assign w_accept  = bus.dec_valid & w_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_div_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept && w_is_div) begin
                    w_state_next = ST_MDIV;
                    w_cnt_next   = CNT_W'(DIV_LAT - 1);
                end
            end
            ST_MDIV: begin
                if (r_cnt == '0) begin
                    w_div_done   = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt - 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
            w_div_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_div_rd <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept && w_is_div) begin
                r_div_rd <= bus.dec_rd;
            end
        end
    end

    // S1 carries single-cycle ops only; a divide re-enters at S2 when it completes,
    // which is safe because nothing is accepted while the divide is outstanding.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_exu_valid <= 1'b0;
            r_exu_op    <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_wb     <= 1'b0;
            r_s1_gpr    <= 1'b0;
            r_s1_rd     <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_wb     <= 1'b0;
            r_s2_gpr    <= 1'b0;
            r_s2_rd     <= '0;
        end else begin
            r_exu_valid <= w_accept;
            r_exu_op    <= w_accept ? w_op : '0;
            r_s1_valid  <= w_accept & ~w_is_div;
            r_s1_wb     <= w_op_valid;
            r_s1_gpr    <= w_wr_gpr;
            r_s1_rd     <= bus.dec_rd;
            if (flush) begin
                r_s2_valid <= 1'b0;
                r_s2_wb    <= 1'b0;
                r_s2_gpr   <= 1'b0;
                r_s2_rd    <= '0;
            end else if (w_div_done) begin
                r_s2_valid <= 1'b1;
                r_s2_wb    <= 1'b1;
                r_s2_gpr   <= 1'b0;
                r_s2_rd    <= r_div_rd;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_wb    <= r_s1_wb;
                r_s2_gpr   <= r_s1_gpr;
                r_s2_rd    <= r_s1_rd;
            end
        end
    end

    assign w_wb_valid      = r_s2_valid & r_s2_wb & ~flush;

    assign bus.dec_ready   = w_ready;
    assign bus.exu_valid   = r_exu_valid;
    assign bus.exu_sfpu_op = r_exu_op;
    assign bus.wb_valid    = w_wb_valid;
    assign bus.wb_rd       = w_wb_valid ? r_s2_rd : 5'd0;
    assign bus.wb_to_gpr   = w_wb_valid & r_s2_gpr;
    assign busy            = r_s1_valid | r_s2_valid | (r_state == ST_MDIV);

`ifdef FPU_SCHED_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_issue_cnt;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            r_stall_cnt <= '0;
            r_issue_cnt <= '0;
        end else begin
            if (bus.dec_valid && !w_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_accept && (r_issue_cnt != '1)) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_issue_cnt = r_issue_cnt;
`endif

endmodule
